// File: rtl/core_pkg.sv
// Shared types and constants for the instruction cache: geometry, FSM states
// and word-address field extraction.
package core_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int LINES  = 16;
    localparam int WPL    = 4;

    localparam int OFF_W  = $clog2(WPL);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND
    } icache_state_t;

    // The word address is {TAG, IDX, OFF}, most significant field first.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] a);
        return addr_fields_t'(a);
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return split_addr(a).off;
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return split_addr(a).idx;
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return split_addr(a).tag;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one write port and one registered read port.
// The read register is reset so the hit path presents zero after reset.
module icache_data_ram #(
    parameter  int DEPTH = 64,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache: 1-cycle hits, whole-line sequential refill
// over a req/ack memory port, and a one-cycle RESPOND for the missed word.
module icache_refill_ctrl
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [DATA_W-1:0] fetch_data_o,
    output logic              data_ready_o,
    input  logic              inv_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    addr_fields_t     fetch_f;
    addr_fields_t     miss_q;
    icache_state_t    state_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [OFF_W-1:0] cnt_q;
    logic             poison_q;
    logic             sel_ram_q;
    logic             data_ready_q;
    logic             mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] resp_q;
    logic [DATA_W-1:0] ram_rdata;
    logic             hit;
    logic             ack;
    logic             last_word;
    logic             ram_we;
    logic             ram_re;

    assign fetch_f   = split_addr(fetch_addr_i);
    // An invalidate in the lookup edge forces a miss even if the line was valid.
    assign hit       = valid_q[fetch_f.idx] && (tag_q[fetch_f.idx] == fetch_f.tag) && !inv_i;
    assign ack       = mem_req_q && mem_ack_i;
    assign last_word = (cnt_q == OFF_W'(WPL - 1));
    assign ram_we    = clk_en_i && (state_q == REFILL) && ack;
    assign ram_re    = clk_en_i && (state_q == IDLE);

    icache_data_ram #(
        .DEPTH (LINES * WPL),
        .DW    (DATA_W)
    ) u_data_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i ({miss_q.idx, cnt_q}),
        .wdata_i (mem_rdata_i),
        .re_i    (ram_re),
        .raddr_i ({fetch_f.idx, fetch_f.off}),
        .rdata_o (ram_rdata)
    );

    // Hits come straight from the RAM read register; refill responses from resp_q.
    assign fetch_data_o = sel_ram_q ? ram_rdata : resp_q;
    assign data_ready_o = data_ready_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
            miss_q       <= '0;
            cnt_q        <= '0;
            poison_q     <= 1'b0;
            sel_ram_q    <= 1'b0;
            data_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            resp_q       <= '0;
        end else if (clk_en_i) begin
            data_ready_q <= 1'b0;
            if (inv_i) begin
                valid_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        data_ready_q <= 1'b1;
                        sel_ram_q    <= 1'b1;
                    end else begin
                        miss_q     <= fetch_f;
                        cnt_q      <= '0;
                        poison_q   <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {fetch_f.tag, fetch_f.idx, {OFF_W{1'b0}}};
                        state_q    <= REFILL;
                    end
                end
                REFILL: begin
                    // An invalidate mid-refill still delivers the word but leaves the line invalid.
                    if (inv_i) begin
                        poison_q <= 1'b1;
                    end
                    if (ack) begin
                        if (cnt_q == miss_q.off) begin
                            resp_q <= mem_rdata_i;
                        end
                        if (last_word) begin
                            mem_req_q           <= 1'b0;
                            tag_q[miss_q.idx]   <= miss_q.tag;
                            if (!(poison_q || inv_i)) begin
                                valid_q[miss_q.idx] <= 1'b1;
                            end
                            sel_ram_q    <= 1'b0;
                            data_ready_q <= 1'b1;
                            state_q      <= RESPOND;
                        end else begin
                            cnt_q      <= cnt_q + OFF_W'(1);
                            mem_addr_q <= {miss_q.tag, miss_q.idx, cnt_q + OFF_W'(1)};
                        end
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: a core-side driver, a randomised
// backing-memory responder and an independent monitor checking responses.
module tb_icache_refill_ctrl;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int WPL   = 4;
    localparam int LINES = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_en = 1'b1;
    logic          inv = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] fetch_data;
    logic          data_ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en_i     (clk_en),
        .fetch_addr_i (fetch_addr),
        .fetch_data_o (fetch_data),
        .data_ready_o (data_ready),
        .inv_i        (inv),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, ~a} ^ 32'h5A3C_0F96;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] expq[$];
    logic [AW-1:0] memq[$];
    bit            mv[LINES];
    int            mt[LINES];
    logic [AW-1:0] seq[$];
    int            resp_cyc[$];
    int            cyc = 0;
    int            acks_seen = 0;
    int            ack_fixed = 0;
    int            ack_max = 0;
    int            en_low_pct = 0;
    int            inv_pct = 0;
    bit            inv_force = 0;
    int            en_burst = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Cache model: the cache is transparent, so every fetch returns memory
    // contents; only misses (by line tag/valid) should cause a 4-word refill.
    task automatic applyStimulus(input logic [AW-1:0] a);
        int ai  = int'(a);
        int idx = (ai / WPL) % LINES;
        int tag = ai / (WPL * LINES);
        fetch_addr = a;
        expq.push_back(mem_word(a));
        if (!(mv[idx] && mt[idx] == tag)) begin
            for (int w = 0; w < WPL; w++) memq.push_back(AW'(ai - (ai % WPL) + w));
            mv[idx] = 1'b1;
            mt[idx] = tag;
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        inv = 1'b0;
        clk_en = 1'b1;
        #1;
        checkOutput("rst_data_ready", data_ready, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_fetch_data", fetch_data, 0);
        expq.delete();
        memq.delete();
        foreach (mv[i]) mv[i] = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Core behaviour: advance to the next address once a response is consumed.
    task automatic runSeq();
        int k = 0;
        int guard = 0;
        resp_cyc.delete();
        applyStimulus(seq[0]);
        while (k < seq.size()) begin
            @(posedge clk);
            #1;
            inv = 1'b0;
            if (en_burst > 0 && mem_req && mem_addr[1:0] == 2'd1) begin
                clk_en = 1'b0;
                en_burst--;
            end else begin
                clk_en = ($urandom_range(0, 99) < en_low_pct) ? 1'b0 : 1'b1;
            end
            if (mem_req && clk_en && (inv_force || $urandom_range(0, 99) < inv_pct)) begin
                inv = 1'b1;
                inv_force = 1'b0;
                foreach (mv[i]) mv[i] = 1'b0;
            end
            @(negedge clk);
            #1;
            if (data_ready && clk_en) begin
                resp_cyc.push_back(cyc);
                k++;
                guard = 0;
                if (k < seq.size()) applyStimulus(seq[k]);
            end else begin
                guard++;
                if (guard > 200) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL timeout: no response for 0x%0h after %0d cycles, required one", seq[k], guard);
                    break;
                end
            end
        end
    endtask

    task automatic endPhase();
        @(posedge clk);
        #1;
        clk_en = 1'b1;
        inv = 1'b0;
        checkOutput("resp_queue_empty", expq.size(), 0);
        checkOutput("mem_queue_empty", memq.size(), 0);
        doReset(2);
    endtask

    // Backing memory: acks each requested word after a (possibly random) delay.
    initial begin
        logic [AW-1:0] last_addr = '0;
        bit            last_req = 1'b0;
        int            dly = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                last_req = 1'b0;
            end else if (!last_req || mem_addr != last_addr) begin
                last_req = 1'b1;
                last_addr = mem_addr;
                dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, ack_max));
                mem_ack = (dly == 0);
            end else if (!mem_ack) begin
                if (dly > 0) dly--;
                mem_ack = (dly == 0);
            end
        end
    end

    initial begin
        bit            prev_ok = 1'b0;
        bit            prev_req = 1'b0;
        bit            prev_cons = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_ok = 1'b0;
            end else begin
                if (data_ready && clk_en) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_data_ready: got data 0x%0h, required no response", fetch_data);
                    end else begin
                        checkOutput("fetch_data", fetch_data, expq.pop_front());
                    end
                end
                if (mem_req && mem_ack && clk_en) begin
                    acks_seen++;
                    if (memq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_mem_req: got addr 0x%0h, required no request", mem_addr);
                    end else begin
                        checkOutput("mem_addr", mem_addr, memq.pop_front());
                    end
                end
                if (mem_req) checkOutput("ready_in_refill", data_ready, 0);
                if (prev_ok && prev_req && !prev_cons) begin
                    checkOutput("req_hold", mem_req, 1);
                    checkOutput("addr_hold", mem_addr, prev_addr);
                end
                prev_ok = 1'b1;
                prev_req = mem_req;
                prev_addr = mem_addr;
                prev_cons = mem_ack && clk_en;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        #2;
        doReset(3);

        // Cold miss, sequential hits, then a conflicting tag in line 0.
        ack_fixed = 0;
        a0 = acks_seen;
        seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0042, 16'h0002};
        runSeq();
        checkOutput("hit_latency_a", (resp_cyc.size() >= 4) ? resp_cyc[2] - resp_cyc[1] : -1, 1);
        checkOutput("hit_latency_b", (resp_cyc.size() >= 4) ? resp_cyc[3] - resp_cyc[2] : -1, 1);
        checkOutput("ack_count_t123", acks_seen - a0, 12);
        endPhase();

        // Slow memory with a clock-enable stall mid-refill, plus top-of-space line.
        ack_fixed = 5;
        en_burst = 3;
        a0 = acks_seen;
        seq = '{16'h0123, 16'hFFFF, 16'hFFFC};
        runSeq();
        checkOutput("ack_count_t4", acks_seen - a0, 8);
        endPhase();

        // Invalidate during refill: word delivered, line left invalid.
        ack_fixed = 1;
        inv_force = 1'b1;
        a0 = acks_seen;
        seq = '{16'h0010, 16'h0010};
        runSeq();
        checkOutput("ack_count_t5", acks_seen - a0, 8);
        endPhase();

        // Reset in the middle of a refill, then a full clean refill.
        ack_fixed = 2;
        applyStimulus(16'h0020);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_addr[1:0] == 2'd2) break;
        end
        checkOutput("t6_at_word2", {mem_req, mem_addr[1:0]}, 3'b110);
        doReset(2);
        a0 = acks_seen;
        seq = '{16'h0020};
        runSeq();
        checkOutput("ack_count_t6", acks_seen - a0, 4);
        endPhase();

        // Random traffic over a few tags so hits, conflicts and wrap all occur.
        ack_fixed = -1;
        ack_max = 3;
        en_low_pct = 20;
        inv_pct = 5;
        seq.delete();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) seq.push_back(AW'(16'hFFFC + $urandom_range(0, 3)));
            else seq.push_back(AW'($urandom_range(0, 3) * 64 + $urandom_range(0, 63)));
        end
        runSeq();
        en_low_pct = 0;
        inv_pct = 0;
        endPhase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
